// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of an RV32I core.
//
// The stage issues at most one data-memory request at a time through a
// two-state FSM (IDLE/ACCESS). While a request is outstanding it holds the
// front of the pipe with stall_mem, then loads the MEM/WB register on the
// cycle dmem_resp arrives. Non-memory instructions pass through in one cycle.
// Misaligned accesses are dropped without a request, and the instruction
// retires with its register write suppressed.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   valid_in            : EX/MEM register holds a real instruction
//   alu_out_in          : effective address or ALU result
//   rs2_in              : store data
//   funct3_in           : load/store width code (bits [1:0] select byte/half/word)
//   br_en_in, u_imm_in, pc_in : pass-through operands
//   ctrl_in[11:0]       : control word
//                         [11] mem_read, [10] mem_write, [9] load_regfile,
//                         [8:4] rd, [3:0] regfilemux_sel
//   dmem_*              : data-memory request (registered) and response
//   stall_mem           : combinational freeze of IF/ID/EX and EX/MEM
//   misaligned          : one-cycle flag for a dropped misaligned access
//   *_wb, data_value, mem_address_last_two_bits, ctrl_wb : MEM/WB register

module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] rs2_in,
  input  logic [2:0]  funct3_in,
  input  logic        br_en_in,
  input  logic [31:0] u_imm_in,
  input  logic [31:0] pc_in,
  input  logic [11:0] ctrl_in,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall_mem,
  output logic        misaligned,
  output logic        valid_wb,
  output logic [31:0] data_value,
  output logic [2:0]  funct3_wb,
  output logic        br_en_wb,
  output logic [31:0] alu_out_wb,
  output logic [31:0] u_imm_wb,
  output logic [31:0] pc_wb,
  output logic [1:0]  mem_address_last_two_bits,
  output logic [11:0] ctrl_wb
);

  localparam int CTRL_MEM_READ     = 11;
  localparam int CTRL_MEM_WRITE    = 10;
  localparam int CTRL_LOAD_REGFILE = 9;

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state_r;
  state_t state_next_s;

  // Byte enables for a store of the given width at byte offset off.
  function automatic logic [3:0] store_mask(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Natural alignment check shared by loads and stores.
  function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

  logic [1:0] off_s;
  logic       mem_op_s;
  logic       aligned_s;
  logic       is_read_s;
  logic       start_s;
  logic       misal_s;

  assign off_s     = alu_out_in[1:0];
  assign mem_op_s  = valid_in & (ctrl_in[CTRL_MEM_READ] | ctrl_in[CTRL_MEM_WRITE]);
  assign aligned_s = is_aligned(funct3_in[1:0], off_s);
  // A read/write conflict resolves to a read.
  assign is_read_s = ctrl_in[CTRL_MEM_READ];
  assign start_s   = (state_r == IDLE) & mem_op_s & aligned_s;
  assign misal_s   = (state_r == IDLE) & mem_op_s & ~aligned_s;
  // Gated by rst so the stall drops immediately when reset asserts.
  assign stall_mem = rst & (start_s | ((state_r == ACCESS) & ~dmem_resp));

  // Instruction fields captured when a request starts.
  logic [2:0]  hold_funct3_r;
  logic        hold_br_en_r;
  logic [31:0] hold_alu_r;
  logic [31:0] hold_u_imm_r;
  logic [31:0] hold_pc_r;
  logic [11:0] hold_ctrl_r;
  logic        hold_read_r;

  // Next MEM/WB contents.
  logic        wb_valid_s;
  logic [31:0] wb_data_s;
  logic [2:0]  wb_funct3_s;
  logic        wb_br_en_s;
  logic [31:0] wb_alu_s;
  logic [31:0] wb_u_imm_s;
  logic [31:0] wb_pc_s;
  logic [11:0] wb_ctrl_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_next_s = ACCESS;
        else         state_next_s = IDLE;
      end
      ACCESS: begin
        if (dmem_resp) state_next_s = IDLE;
        else           state_next_s = ACCESS;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // MEM/WB next-value selection; anything not loading becomes an all-zero bubble.
  always_comb begin
    wb_valid_s  = 1'b0;
    wb_data_s   = 32'h0000_0000;
    wb_funct3_s = 3'b000;
    wb_br_en_s  = 1'b0;
    wb_alu_s    = 32'h0000_0000;
    wb_u_imm_s  = 32'h0000_0000;
    wb_pc_s     = 32'h0000_0000;
    wb_ctrl_s   = 12'h000;
    if (state_r == ACCESS) begin
      if (dmem_resp) begin
        wb_valid_s  = 1'b1;
        wb_data_s   = hold_read_r ? dmem_rdata : 32'h0000_0000;
        wb_funct3_s = hold_funct3_r;
        wb_br_en_s  = hold_br_en_r;
        wb_alu_s    = hold_alu_r;
        wb_u_imm_s  = hold_u_imm_r;
        wb_pc_s     = hold_pc_r;
        wb_ctrl_s   = hold_ctrl_r;
      end else begin
        wb_valid_s  = 1'b0;
      end
    end else if (valid_in && !start_s) begin
      // Non-memory op, or a misaligned access retired without a request.
      wb_valid_s  = 1'b1;
      wb_funct3_s = funct3_in;
      wb_br_en_s  = br_en_in;
      wb_alu_s    = alu_out_in;
      wb_u_imm_s  = u_imm_in;
      wb_pc_s     = pc_in;
      wb_ctrl_s   = ctrl_in;
      wb_ctrl_s[CTRL_LOAD_REGFILE] = ctrl_in[CTRL_LOAD_REGFILE] & ~misal_s;
    end else begin
      wb_valid_s  = 1'b0;
    end
  end

  // Memory request registers and captured instruction; stable throughout ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_address  <= 32'h0000_0000;
      dmem_read     <= 1'b0;
      dmem_write    <= 1'b0;
      dmem_wmask    <= 4'b0000;
      dmem_wdata    <= 32'h0000_0000;
      hold_funct3_r <= 3'b000;
      hold_br_en_r  <= 1'b0;
      hold_alu_r    <= 32'h0000_0000;
      hold_u_imm_r  <= 32'h0000_0000;
      hold_pc_r     <= 32'h0000_0000;
      hold_ctrl_r   <= 12'h000;
      hold_read_r   <= 1'b0;
    end else if (start_s) begin
      dmem_address  <= {alu_out_in[31:2], 2'b00};
      dmem_read     <= is_read_s;
      dmem_write    <= ~is_read_s;
      dmem_wmask    <= is_read_s ? 4'b0000 : store_mask(funct3_in[1:0], off_s);
      dmem_wdata    <= rs2_in << {off_s, 3'b000};
      hold_funct3_r <= funct3_in;
      hold_br_en_r  <= br_en_in;
      hold_alu_r    <= alu_out_in;
      hold_u_imm_r  <= u_imm_in;
      hold_pc_r     <= pc_in;
      hold_ctrl_r   <= ctrl_in;
      hold_read_r   <= is_read_s;
    end else if ((state_r == ACCESS) && dmem_resp) begin
      dmem_read     <= 1'b0;
      dmem_write    <= 1'b0;
    end
  end

  // MEM/WB register and misaligned flag; loads every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_wb                  <= 1'b0;
      data_value                <= 32'h0000_0000;
      funct3_wb                 <= 3'b000;
      br_en_wb                  <= 1'b0;
      alu_out_wb                <= 32'h0000_0000;
      u_imm_wb                  <= 32'h0000_0000;
      pc_wb                     <= 32'h0000_0000;
      mem_address_last_two_bits <= 2'b00;
      ctrl_wb                   <= 12'h000;
      misaligned                <= 1'b0;
    end else begin
      valid_wb                  <= wb_valid_s;
      data_value                <= wb_data_s;
      funct3_wb                 <= wb_funct3_s;
      br_en_wb                  <= wb_br_en_s;
      alu_out_wb                <= wb_alu_s;
      u_imm_wb                  <= wb_u_imm_s;
      pc_wb                     <= wb_pc_s;
      mem_address_last_two_bits <= wb_alu_s[1:0];
      ctrl_wb                   <= wb_ctrl_s;
      misaligned                <= misal_s;
    end
  end

endmodule
